// File: rtl/tdc_multistop_proc.sv
// Multi-stop TDC post-processor: serial popcount phase decode per snapshot, one coarse/fine
// interval record per stop channel. Define TDC_MISS_REPORT_EN to also emit records for silent channels.
module tdc_multistop_proc #(
  parameter int CHAIN_LEN      = 143,
  parameter int NUM_STOP       = 4,
  parameter int COARSE_W       = 32,
  parameter int FINE_W         = 9,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int CH_W          = (NUM_STOP > 1) ? $clog2(NUM_STOP) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_valid,
  input  logic [CHAIN_LEN-1:0]           start_code,
  input  logic                           start_level,
  input  logic [COARSE_W-1:0]            start_coarse,
  input  logic [NUM_STOP-1:0]            stop_valid,
  input  logic [NUM_STOP*CHAIN_LEN-1:0]  stop_code,
  input  logic [NUM_STOP-1:0]            stop_level,
  input  logic [NUM_STOP*COARSE_W-1:0]   stop_coarse,
  output logic                           busy,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [CH_W-1:0]                res_channel,
  output logic [COARSE_W-1:0]            res_coarse,
  output logic [FINE_W-1:0]              res_fine,
  output logic                           res_neg,
  output logic                           res_miss
);

  localparam int PTR_W = CH_W + 1;
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WIN_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DEC_START, S_SCAN, S_DEC_STOP, S_CALC, S_OUT
  } state_t;

  typedef struct packed {
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fine;
    logic                neg;
  } interval_t;

  // Phase difference wraps into 0..2*CHAIN_LEN-1 with a borrow taken from the coarse count.
  function automatic interval_t calc_interval(input logic [FINE_W-1:0]   ph_start,
                                              input logic [FINE_W-1:0]   ph_stop,
                                              input logic [COARSE_W-1:0] c_start,
                                              input logic [COARSE_W-1:0] c_stop);
    logic signed [FINE_W:0] d;
    logic signed [FINE_W:0] d_wrap;
    logic                   borrow;
    interval_t              r;
    d      = $signed({1'b0, ph_stop}) - $signed({1'b0, ph_start});
    d_wrap = d + $signed((FINE_W+1)'(2 * CHAIN_LEN));
    borrow = d[FINE_W];
    r.fine   = borrow ? d_wrap[FINE_W-1:0] : d[FINE_W-1:0];
    r.coarse = c_stop - c_start - COARSE_W'(borrow);
    r.neg    = (c_stop == c_start) && borrow;
    if (r.neg) begin
      r.coarse = '0;
      r.fine   = '0;
    end
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic [NUM_STOP-1:0]     hit;
  logic [WIN_W-1:0]        win_cnt;
  logic [CNT_W-1:0]        dec_cnt;
  logic [PTR_W-1:0]        ch;
  logic [CHAIN_LEN-1:0]    start_code_q;
  logic                    start_level_q;
  logic [COARSE_W-1:0]     start_coarse_q;
  logic [CHAIN_LEN-1:0]    stop_code_q   [NUM_STOP];
  logic [NUM_STOP-1:0]     stop_level_q;
  logic [COARSE_W-1:0]     stop_coarse_q [NUM_STOP];
  logic [CHAIN_LEN-1:0]    sh;
  logic                    dec_level;
  logic [FINE_W-1:0]       acc;
  logic [FINE_W-1:0]       start_phase_q;
  logic                    bit_in, dec_last, hit_all, win_last;
  logic                    scan_found, scan_hit;
  logic [PTR_W-1:0]        scan_sel;
  interval_t               iv;

  assign busy     = (state_q != S_IDLE);
  assign bit_in   = (sh[0] == dec_level);
  assign dec_last = (dec_cnt == CNT_W'(CHAIN_LEN - 1));
  assign hit_all  = &(hit | stop_valid);
  assign win_last = (win_cnt == WIN_W'(TIMEOUT_CYCLES - 1));
  assign iv       = calc_interval(start_phase_q, acc, start_coarse_q, stop_coarse_q[ch[CH_W-1:0]]);

  always_comb begin
    scan_found = 1'b0;
    scan_hit   = 1'b0;
    scan_sel   = ch;
`ifdef TDC_MISS_REPORT_EN
    if (ch < PTR_W'(NUM_STOP)) begin
      scan_found = 1'b1;
      scan_hit   = hit[ch[CH_W-1:0]];
    end
`else
    // Walk downwards so the lowest qualifying channel is the one that sticks.
    for (int k = NUM_STOP - 1; k >= 0; k--) begin
      if (hit[k] && (PTR_W'(k) >= ch)) begin
        scan_found = 1'b1;
        scan_sel   = PTR_W'(k);
      end
    end
    scan_hit = scan_found;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (start_valid) state_d = S_ARMED;
      S_ARMED:     if (hit_all || win_last) state_d = S_DEC_START;
      S_DEC_START: if (dec_last) state_d = S_SCAN;
      S_SCAN: begin
        if (!scan_found)   state_d = S_IDLE;
        else if (scan_hit) state_d = S_DEC_STOP;
        else               state_d = S_CALC;
      end
      S_DEC_STOP:  if (dec_last) state_d = S_CALC;
      S_CALC:      state_d = S_OUT;
      S_OUT:       if (res_ready) state_d = S_SCAN;
      default:     state_d = S_IDLE;
    endcase
  end

  logic cur_miss;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit         <= '0;
      win_cnt     <= '0;
      dec_cnt     <= '0;
      ch          <= '0;
      cur_miss    <= 1'b0;
      res_valid   <= 1'b0;
      res_channel <= '0;
      res_coarse  <= '0;
      res_fine    <= '0;
      res_neg     <= 1'b0;
`ifdef TDC_MISS_REPORT_EN
      res_miss    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_valid) begin
            hit     <= '0;
            win_cnt <= '0;
            ch      <= '0;
          end
        end
        S_ARMED: begin
          hit     <= hit | stop_valid;
          win_cnt <= win_cnt + WIN_W'(1);
          dec_cnt <= '0;
        end
        S_DEC_START, S_DEC_STOP: dec_cnt <= dec_last ? '0 : dec_cnt + CNT_W'(1);
        S_SCAN: begin
          ch       <= scan_sel;
          cur_miss <= !scan_hit;
          dec_cnt  <= '0;
        end
        S_CALC: begin
          res_valid   <= 1'b1;
          res_channel <= ch[CH_W-1:0];
          res_coarse  <= iv.coarse;
          res_fine    <= iv.fine;
          res_neg     <= iv.neg;
`ifdef TDC_MISS_REPORT_EN
          res_miss    <= cur_miss;
          if (cur_miss) begin
            res_coarse <= '1;
            res_fine   <= '0;
            res_neg    <= 1'b0;
          end
`endif
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ch        <= ch + PTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifndef TDC_MISS_REPORT_EN
  assign res_miss = 1'b0;
`endif

  // Snapshot capture and serial decoder; no reset needed, every use is gated by the FSM.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start_valid) begin
      start_code_q   <= start_code;
      start_level_q  <= start_level;
      start_coarse_q <= start_coarse;
    end
    if (state_q == S_ARMED) begin
      for (int k = 0; k < NUM_STOP; k++) begin
        if (stop_valid[k] && !hit[k]) begin
          stop_code_q[k]   <= stop_code[k*CHAIN_LEN +: CHAIN_LEN];
          stop_level_q[k]  <= stop_level[k];
          stop_coarse_q[k] <= stop_coarse[k*COARSE_W +: COARSE_W];
        end
      end
    end
    if (state_q == S_ARMED && state_d == S_DEC_START) begin
      sh        <= start_code_q;
      dec_level <= start_level_q;
      acc       <= start_level_q ? '0 : FINE_W'(CHAIN_LEN);
    end
    if (state_q == S_DEC_START || state_q == S_DEC_STOP) begin
      sh  <= sh >> 1;
      acc <= acc + FINE_W'(bit_in);
    end
    if (state_q == S_DEC_START && dec_last) start_phase_q <= acc + FINE_W'(bit_in);
    if (state_q == S_SCAN) begin
      sh        <= stop_code_q[scan_sel[CH_W-1:0]];
      dec_level <= stop_level_q[scan_sel[CH_W-1:0]];
      acc       <= stop_level_q[scan_sel[CH_W-1:0]] ? '0 : FINE_W'(CHAIN_LEN);
    end
  end

endmodule

// File: tb/tb_tdc_multistop_proc.sv
// Directed bench for tdc_multistop_proc (default build, TDC_MISS_REPORT_EN undefined).
module tb_tdc_multistop_proc;
  localparam int CL = 143, NS = 4, CW = 32, FW = 9, TO = 64;
  localparam int LAT_TIMEOUT = TO + 2 * CL + 2;
  localparam int LAT_ALLHIT  = 1 + 2 * CL + 2;
  localparam int LAT_NEXT    = CL + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_valid;
  logic [CL-1:0]     start_code;
  logic              start_level;
  logic [CW-1:0]     start_coarse;
  logic [NS-1:0]     stop_valid;
  logic [NS*CL-1:0]  stop_code;
  logic [NS-1:0]     stop_level;
  logic [NS*CW-1:0]  stop_coarse;
  logic              busy, res_valid, res_ready, res_neg, res_miss;
  logic [1:0]        res_channel;
  logic [CW-1:0]     res_coarse;
  logic [FW-1:0]     res_fine;

  int checks = 0, failures = 0;
  int cyc = 0;
  int c0, h;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tdc_multistop_proc dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_code(start_code),
    .start_level(start_level), .start_coarse(start_coarse), .stop_valid(stop_valid),
    .stop_code(stop_code), .stop_level(stop_level), .stop_coarse(stop_coarse),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_channel(res_channel),
    .res_coarse(res_coarse), .res_fine(res_fine), .res_neg(res_neg), .res_miss(res_miss)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CL-1:0] therm(input int n);
    logic [CL-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_stop(input int k, input logic [CL-1:0] code, input logic lvl,
                          input logic [CW-1:0] coarse);
    stop_code[k*CL +: CL]   = code;
    stop_level[k]           = lvl;
    stop_coarse[k*CW +: CW] = coarse;
  endtask

  task automatic do_start(input logic [CL-1:0] code, input logic lvl,
                          input logic [CW-1:0] coarse, output int t0);
    start_code = code; start_level = lvl; start_coarse = coarse; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic pulse_stop(input logic [NS-1:0] mask);
    stop_valid = mask;
    tick();
    stop_valid = '0;
  endtask

  task automatic wait_valid(input string tag, input int from, input int exp_lat);
    int n;
    n = 0;
    while (!res_valid && n < 1000) begin tick(); n++; end
    chk({tag, "_latency"}, 64'(cyc - from), 64'(exp_lat));
  endtask

  task automatic chk_rec(input string tag, input int ch, input logic [CW-1:0] co,
                         input int fi, input logic ng);
    chk({tag, "_valid"},   res_valid, 1);
    chk({tag, "_channel"}, res_channel, 64'(ch));
    chk({tag, "_coarse"},  res_coarse, co);
    chk({tag, "_fine"},    res_fine, 64'(fi));
    chk({tag, "_neg"},     res_neg, ng);
    chk({tag, "_miss"},    res_miss, 0);
  endtask

  task automatic accept(input string tag, output int hs);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    hs = cyc;
    chk({tag, "_valid_drop"}, res_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; start_code = '0; start_level = 1'b0; start_coarse = '0;
    stop_valid = '0; stop_code = '0; stop_level = '0; stop_coarse = '0; res_ready = 1'b0;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_channel", res_channel, 0);
    chk("rst_coarse", res_coarse, 0);
    chk("rst_fine", res_fine, 0);
    chk("rst_neg", res_neg, 0);
    chk("rst_miss", res_miss, 0);
    rst_n = 1'b1;
    tick();

    // Basic: phases 10 -> 50, coarse 5 -> 7, closes on timeout.
    do_start(therm(10), 1'b1, 32'd5, c0);
    chk("basic_busy", busy, 1);
    set_stop(0, therm(50), 1'b1, 32'd7);
    pulse_stop(4'b0001);
    wait_valid("basic", c0, LAT_TIMEOUT);
    chk_rec("basic", 0, 32'd2, 40, 1'b0);
    accept("basic", h);
    tick(2);
    chk("basic_idle", busy, 0);

    // Borrow: start phase 143+20=163, stop phase 30.
    do_start(therm(123), 1'b0, 32'd10, c0);
    tick(5);
    set_stop(1, therm(30), 1'b1, 32'd12);
    pulse_stop(4'b0010);
    wait_valid("borrow", c0, LAT_TIMEOUT);
    chk_rec("borrow", 1, 32'd1, 153, 1'b0);
    accept("borrow", h);
    tick(2);

    // Negative interval: equal coarse, stop phase below start phase.
    do_start(therm(100), 1'b1, 32'd9, c0);
    set_stop(0, therm(40), 1'b1, 32'd9);
    pulse_stop(4'b0001);
    wait_valid("neg", c0, LAT_TIMEOUT);
    chk_rec("neg", 0, 32'd0, 0, 1'b1);
    accept("neg", h);
    tick(2);

    // Ordering, coarse wrap and duplicate stop: ch2 first, ch0 later, ch0 repeated.
    do_start(therm(143), 1'b1, 32'hFFFF_FFFE, c0);
    set_stop(2, therm(0), 1'b0, 32'd1);
    pulse_stop(4'b0100);
    tick(3);
    set_stop(0, therm(7), 1'b0, 32'hFFFF_FFFE);
    pulse_stop(4'b0001);
    set_stop(0, therm(100), 1'b1, 32'h55);
    pulse_stop(4'b0001);
    wait_valid("order0", c0, LAT_TIMEOUT);
    chk_rec("order0", 0, 32'd0, 136, 1'b0);
    accept("order0", h);
    wait_valid("order2", h, LAT_NEXT);
    chk_rec("order2", 2, 32'd3, 143, 1'b0);
    accept("order2", h);
    tick(2);
    chk("order_idle", busy, 0);

    // Backpressure; stop with start ignored; stop in last window cycle accepted.
    set_stop(0, therm(5), 1'b1, 32'd20);
    stop_valid = 4'b0001;
    do_start(therm(50), 1'b1, 32'd20, c0);
    stop_valid = '0;
    tick(2);
    set_stop(3, therm(60), 1'b1, 32'd21);
    pulse_stop(4'b1000);
    while (cyc < c0 + TO - 1) tick();
    set_stop(1, therm(50), 1'b0, 32'd20);
    pulse_stop(4'b0010);
    wait_valid("bp1", c0, LAT_TIMEOUT);
    chk_rec("bp1", 1, 32'd0, 186, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        start_code = therm(1); start_coarse = 32'd999; start_valid = 1'b1;
      end
      tick();
      start_valid = 1'b0;
      chk("bp_hold_valid", res_valid, 1);
      chk("bp_hold_channel", res_channel, 1);
      chk("bp_hold_fine", res_fine, 186);
      chk("bp_hold_busy", busy, 1);
    end
    accept("bp1", h);
    wait_valid("bp3", h, LAT_NEXT);
    chk_rec("bp3", 3, 32'd1, 10, 1'b0);
    accept("bp3", h);
    tick(2);
    chk("bp_idle", busy, 0);

    // Reset in the middle of DEC_STOP, then an immediate new start.
    do_start(therm(0), 1'b1, 32'd0, c0);
    set_stop(0, therm(3), 1'b1, 32'd0);
    pulse_stop(4'b0001);
    while (cyc < c0 + TO + CL + 1 + 50) tick();
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", res_valid, 0);
    chk("midrst_channel", res_channel, 0);
    chk("midrst_fine", res_fine, 0);
    chk("midrst_coarse", res_coarse, 0);
    rst_n = 1'b1;
    tick();
    do_start(therm(0), 1'b1, 32'd0, c0);
    chk("post_rst_busy", busy, 1);
    set_stop(0, therm(1), 1'b1, 32'd0);
    pulse_stop(4'b0001);
    wait_valid("post_rst", c0, LAT_TIMEOUT);
    chk_rec("post_rst", 0, 32'd0, 1, 1'b0);
    accept("post_rst", h);
    tick(2);

    // All channels hit together: window closes early, records in channel order.
    do_start(therm(0), 1'b1, 32'd0, c0);
    for (int k = 0; k < NS; k++) set_stop(k, therm(k + 1), 1'b1, 32'd0);
    pulse_stop(4'b1111);
    wait_valid("all0", c0, LAT_ALLHIT);
    for (int k = 0; k < NS; k++) begin
      if (k > 0) wait_valid("all_next", h, LAT_NEXT);
      chk_rec("all", k, 32'd0, k + 1, 1'b0);
      accept("all", h);
    end
    tick(2);
    chk("all_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tdc_multistop_proc.md
# tdc_multistop_proc

Parametrised multi-stop successor to the single-channel TDC post-processing. It takes one start snapshot and up to NUM_STOP stop snapshots already captured from the delay line and synchronised into `clk`. It decodes each thermometer code to a phase with a serial counter, then emits one coarse/fine interval record per stop channel over a valid/ready port. It sits between the delay-line capture flops and the SPI readout.

## Interface
- CHAIN_LEN, 143: delay-line taps; one half sampling-clock period equals CHAIN_LEN taps.
- NUM_STOP, 4: stop channels.
- COARSE_W, 32: coarse counter width.
- FINE_W, 9: fine result width; must satisfy 2^FINE_W ≥ 2*CHAIN_LEN.
- TIMEOUT_CYCLES, 64: acceptance window length in `clk` cycles after start.
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start_valid  in  1  one-cycle start event strobe.
- start_code  in  CHAIN_LEN  start thermometer snapshot.
- start_level  in  1  sampling-clock level at start capture.
- start_coarse  in  COARSE_W  coarse count at start.
- stop_valid  in  NUM_STOP  per-channel stop strobes.
- stop_code  in  NUM_STOP*CHAIN_LEN  stop snapshots; channel k is at [k*CHAIN_LEN +: CHAIN_LEN].
- stop_level  in  NUM_STOP  per-channel sampling-clock level.
- stop_coarse  in  NUM_STOP*COARSE_W  per-channel coarse count.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accepts the record.
- res_channel  out  clog2(NUM_STOP) (min 1)  stop channel index.
- res_coarse  out  COARSE_W  interval coarse part.
- res_fine  out  FINE_W  interval fine part, range 0..2*CHAIN_LEN-1.
- res_neg  out  1  stop precedes start; coarse and fine are forced to 0.
- res_miss  out  1  no stop in window (only with the macro; otherwise tied to 0).

## Operation
- Phase of a snapshot: the level=1 case gives popcount(code). The level=0 case gives CHAIN_LEN + popcount(~code). Popcount makes the decode bubble-tolerant.
- Interval: d = stop_phase − start_phase. If d < 0: fine = d + 2*CHAIN_LEN and borrow = 1; otherwise fine = d and borrow = 0. Coarse = stop_coarse − start_coarse − borrow, computed mod 2^COARSE_W so counter wrap is handled.
- Negative interval: when stop_coarse == start_coarse and borrow = 1, res_neg = 1 and res_coarse = res_fine = 0.
- FSM states and transitions:
  - IDLE: start_valid latches the start snapshot and goes to ARMED.
  - ARMED: the first stop_valid[k] per channel latches that channel's snapshot and sets hit[k]; further stops on channel k are ignored. Leave to DEC_START when all hit bits are set, or at window cycle TIMEOUT_CYCLES-1. A stop arriving in that final cycle is accepted.
  - DEC_START: CHAIN_LEN cycles, shifting one bit per cycle into the phase counter.
  - SCAN: 1 cycle; finds the lowest channel ≥ current channel that has hit set (or any channel, with the macro). If none is found, go to IDLE.
  - DEC_STOP: CHAIN_LEN cycles.
  - CALC: 1 cycle; loads the result registers and sets res_valid.
  - OUT: hold until res_ready, then advance the channel and return to SCAN.
- start_valid outside IDLE is ignored. stop_valid outside ARMED is ignored, including a stop in the same cycle as start_valid.
- Reset values: busy=0, res_valid=0, res_channel=0, res_coarse=0, res_fine=0, res_neg=0, res_miss=0. Hit bits are cleared and the FSM goes to IDLE.

## Timing
- Window close at cycle t: DEC_START runs t+1..t+CHAIN_LEN, SCAN at t+CHAIN_LEN+1, DEC_STOP runs through t+2*CHAIN_LEN+1, CALC at t+2*CHAIN_LEN+2. res_valid is high from t+2*CHAIN_LEN+3.
- Each further record: CHAIN_LEN+2 cycles after the previous handshake.
- Handshake: a transfer occurs when res_valid && res_ready. The record fields stay stable while res_valid && !res_ready. res_valid drops the cycle after the transfer.
- Records are emitted in ascending channel order, independent of stop arrival order.
- When rst_n is low at an edge: all outputs take their reset values on that edge, mid-operation included, and any in-flight record is discarded.

## Configuration
- TDC_MISS_REPORT_EN defined: a channel without a hit still produces a record, with res_miss=1, res_coarse = all ones, res_fine=0, res_neg=0. SCAN visits every channel, and that channel's DEC_STOP is skipped (SCAN→CALC).
- Undefined: missed channels produce no record and res_miss is constant 0.

## Test plan
Defaults apply: CHAIN_LEN=143, NUM_STOP=4, TIMEOUT_CYCLES=64.
- Basic: start has 10 ones, level 1, coarse 5; ch0 stop has 50 ones, level 1, coarse 7; other channels are silent. -> One record: ch0, coarse 2, fine 40, neg 0, at t+289.
- Borrow: start has 20 zeros, level 0 (phase 163), coarse 10; ch1 stop has 30 ones, level 1, coarse 12. -> ch1, coarse 1, fine 153.
- Negative: start phase 100, ch0 stop phase 40, equal coarse 9. -> res_neg=1, coarse 0, fine 0.
- Ordering and miss: ch2 stop before ch0 stop; ch1 and ch3 silent; timeout. -> Records ch0 then ch2. With TDC_MISS_REPORT_EN: ch0, ch1 (miss, coarse 0xFFFFFFFF), ch2, ch3 (miss).
- Backpressure: res_ready low for 20 cycles, plus a start_valid pulse during OUT. -> Record fields stable, busy=1, the start is ignored, the next record follows after the handshake.
- Reset mid-DEC_STOP: rst_n low for 1 cycle. -> busy=0, res_valid=0 from that edge; a new start is accepted the cycle after rst_n returns high.
